bcd_scan_display: RTL and testbench

- Multiplexed N-digit 7-segment driver that time-shares one shared segment bus across N common-anode/cathode digits.
- Takes a packed vector of 4-bit codes, snapshots it on a load strobe, and scans the digits round-robin with a programmable dwell time.
- Adds dead-time anti-ghosting, leading-zero suppression, per-digit blink and a frame-complete pulse.
- Sits between the datapath result/status logic and the board display pins.

---
 rtl/bcd_scan_display.sv | 134 +++++++++++++
 tb/tb_bcd_scan_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed N-digit 7-segment scanner: snapshots digit codes on load and
// time-shares one segment bus with dead time, leading-zero blanking and blink.
module bcd_scan_display #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     blink_en,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]          SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [3:0]          shadow [N_DIGITS];
    logic [IDX_W-1:0]    idx;
    logic [DIV_W-1:0]    div_cnt;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blink_phase;

    logic                slot_end;
    logic                frame_end;
    logic                nonzero_above;
    logic [N_DIGITS-1:0] suppress;
    logic [6:0]          lit;
    logic [N_DIGITS-1:0] an_on;
    logic [6:0]          seg_next;
    logic [N_DIGITS-1:0] an_next;

    // Lit pattern {a..g} in active-high form; codes 12..15 are blank.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            4'd10:   decode = 7'b0000001;
            4'd11:   decode = 7'b1000111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // A digit is a leading zero only if it and every more significant digit are 0.
    always_comb begin
        suppress      = '0;
        nonzero_above = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (shadow[k] != 4'd0) begin
                nonzero_above = 1'b1;
            end
            suppress[k] = blank_lz && !nonzero_above;
        end
    end

    always_comb begin
        lit   = decode(shadow[idx]);
        an_on = '0;
        if (suppress[idx] || (!blink_phase && blink_en[idx])) begin
            lit = 7'b0000000;
        end
        if (div_cnt != '0) begin
            an_on[idx] = 1'b1;
        end else begin
            lit = 7'b0000000;
        end
        seg_next = lit ^ SEG_OFF;
        an_next  = an_on ^ AN_OFF;
    end

    // Outputs are registered from the pre-edge state, so they trail the scan by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                shadow[k] <= 4'hF;
            end
            idx         <= '0;
            div_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_done  <= 1'b0;
        end else begin
            if (load) begin
                for (int k = 0; k < N_DIGITS; k++) begin
                    shadow[k] <= digits_in[4*k +: 4];
                end
            end
            seg        <= seg_next;
            an         <= an_next;
            frame_done <= frame_end;
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (frame_end) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with 4 digits, 4-cycle slots and
// 2-frame blink phases; each table row describes one full 16-cycle frame.
module tb_bcd_scan_display;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0]     digits;
        logic            load;
        logic            blank_lz;
        logic [3:0]      blink_en;
        logic [3:0][6:0] exp_seg;
    } vec_t;

    vec_t vecs [16];

    bcd_scan_display #(
        .N_DIGITS      (4),
        .SCAN_DIV      (4),
        .BLINK_FRAMES  (2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic ld,
                                  input logic lz, input logic [3:0] bl);
        digits_in = d;
        load      = ld;
        blank_lz  = lz;
        blink_en  = bl;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("reset%0d_an", i), 32'(an), 32'h0F);
            check_output($sformatf("reset%0d_seg", i), 32'(seg), 32'h7F);
            check_output($sformatf("reset%0d_fd", i), 32'(frame_done), 32'h0);
        end
        rst = 1'b0;
    endtask

    // Each slot: one dead-time cycle then three lit cycles; frame_done marks the last cycle.
    task automatic run_frame(input int v);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        apply_stimulus(vecs[v].digits, vecs[v].load, vecs[v].blank_lz, vecs[v].blink_en);
        for (int t = 0; t < 16; t++) begin
            tick();
            load = 1'b0;
            if ((t % 4) == 0) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(4'b0001 << (t / 4));
                exp_seg = vecs[v].exp_seg[t / 4];
            end
            check_output($sformatf("v%0d_t%0d_an", v, t), 32'(an), 32'(exp_an));
            check_output($sformatf("v%0d_t%0d_seg", v, t), 32'(seg), 32'(exp_seg));
            check_output($sformatf("v%0d_t%0d_fd", v, t), 32'(frame_done), 32'(t == 15));
        end
    endtask

    initial begin
        // exp_seg lists digits 3,2,1,0 in active-low form
        vecs[0]  = '{16'hFFFF, 1'b0, 1'b0, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[1]  = '{16'h1234, 1'b1, 1'b0, 4'h0, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[2]  = '{16'h0070, 1'b1, 1'b1, 4'h0, {7'h7F, 7'h7F, 7'h0F, 7'h01}};
        vecs[3]  = '{16'h0070, 1'b0, 1'b0, 4'h0, {7'h01, 7'h01, 7'h0F, 7'h01}};
        vecs[4]  = '{16'h0000, 1'b1, 1'b1, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[5]  = '{16'hABCF, 1'b1, 1'b0, 4'h0, {7'h7E, 7'h38, 7'h7F, 7'h7F}};
        vecs[6]  = '{16'h0A05, 1'b1, 1'b1, 4'h0, {7'h7F, 7'h7E, 7'h01, 7'h24}};
        vecs[7]  = '{16'h5678, 1'b1, 1'b0, 4'h0, {7'h24, 7'h20, 7'h0F, 7'h00}};
        vecs[8]  = '{16'h9001, 1'b1, 1'b1, 4'h0, {7'h04, 7'h01, 7'h01, 7'h4F}};
        vecs[9]  = '{16'h1234, 1'b1, 1'b0, 4'h1, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[10] = '{16'h1234, 1'b0, 1'b0, 4'h1, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[11] = '{16'h1234, 1'b0, 1'b0, 4'h1, {7'h4F, 7'h12, 7'h06, 7'h7F}};
        vecs[12] = '{16'h1234, 1'b0, 1'b0, 4'h1, {7'h4F, 7'h12, 7'h06, 7'h7F}};
        vecs[13] = '{16'h1234, 1'b0, 1'b0, 4'h1, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[14] = '{16'h1234, 1'b0, 1'b0, 4'h1, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[15] = '{16'h1234, 1'b1, 1'b0, 4'h0, {7'h4F, 7'h12, 7'h06, 7'h4C}};

        apply_stimulus(16'h0000, 1'b0, 1'b0, 4'h0);
        do_reset();
        for (int v = 0; v < 16; v++) begin
            if (v == 9) begin
                do_reset();
            end
            run_frame(v);
        end

        // Load on the edge where the scan leaves digit 0 for digit 1.
        tick();
        tick();
        tick();
        apply_stimulus(16'h9999, 1'b1, 1'b0, 4'h0);
        tick();
        load = 1'b0;
        check_output("mid_old_d0_an", 32'(an), 32'h0E);
        check_output("mid_old_d0_seg", 32'(seg), 32'h4C);
        tick();
        check_output("mid_dead_an", 32'(an), 32'h0F);
        check_output("mid_dead_seg", 32'(seg), 32'h7F);
        tick();
        check_output("mid_new_d1_an", 32'(an), 32'h0D);
        check_output("mid_new_d1_seg", 32'(seg), 32'h04);
        tick();
        tick();
        tick();
        check_output("mid_d2_dead_an", 32'(an), 32'h0F);
        tick();
        check_output("mid_d2_an", 32'(an), 32'h0B);
        check_output("mid_d2_seg", 32'(seg), 32'h04);

        // Reset while digit 2 is being shown.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst_an", 32'(an), 32'h0F);
        check_output("midrst_seg", 32'(seg), 32'h7F);
        check_output("midrst_fd", 32'(frame_done), 32'h0);
        tick();
        check_output("restart_dead_an", 32'(an), 32'h0F);
        tick();
        check_output("restart_d0_an", 32'(an), 32'h0E);
        check_output("restart_d0_seg", 32'(seg), 32'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
